// File: rtl/req_encoder8.sv
// Sequential 8-to-3 request encoder: captures request lines as pending and grants one index at a time over valid/ready.
// Define REQ_ENC_RR_EN for round-robin selection; the default build uses fixed lowest-index priority.
module req_encoder8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       ENABLE,
  input  logic [7:0] Din,
  input  logic       ready,
  output logic [2:0] Aout,
  output logic       valid,
  output logic [7:0] pending,
  output logic [3:0] pend_cnt,
  output logic       dup
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t     state_q;
  logic [7:0] pending_q, pending_d;
  logic [2:0] aout_q;
  logic       dup_q, dup_d;
  logic [2:0] sel;
  logic       any_pend;
  logic       load;
  logic [7:0] clr;
  logic [7:0] din_gated;
  logic [3:0] cnt;

`ifdef REQ_ENC_RR_EN
  logic [2:0] last_q;
  logic [2:0] rr_idx;
  logic       found;

  // Search starts one past the last grant and wraps; k=8 revisits last itself.
  always_comb begin
    sel    = last_q;
    found  = 1'b0;
    rr_idx = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      rr_idx = last_q + k[2:0];
      if (!found && pending_q[rr_idx]) begin
        sel   = rr_idx;
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pending_q[i]) sel = i[2:0];
    end
  end
`endif

  assign any_pend  = |pending_q;
  assign load      = any_pend && ((state_q == IDLE) || ready);
  assign clr       = load ? (8'd1 << sel) : 8'd0;
  assign din_gated = ENABLE ? Din : 8'd0;
  assign pending_d = (pending_q & ~clr) | din_gated;
  assign dup_d     = |(din_gated & pending_q & ~clr);

  always_comb begin
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'd0, pending_q[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 8'd0;
      aout_q    <= 3'd0;
      dup_q     <= 1'b0;
`ifdef REQ_ENC_RR_EN
      last_q    <= 3'd7;
`endif
    end else begin
      pending_q <= pending_d;
      dup_q     <= dup_d;
      case (state_q)
        IDLE: begin
          if (any_pend) begin
            aout_q  <= sel;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (ready) begin
            if (any_pend) aout_q <= sel;
            else          state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
`ifdef REQ_ENC_RR_EN
      if (load) last_q <= sel;
`endif
    end
  end

  assign Aout     = aout_q;
  assign valid    = (state_q == HOLD);
  assign pending  = pending_q;
  assign pend_cnt = cnt;
  assign dup      = dup_q;

endmodule

// File: tb/tb_req_encoder8.sv
// Directed-vector bench for req_encoder8: each record gives inputs for one cycle and the outputs expected after that edge.
module tb_req_encoder8;

  logic       clk = 1'b0;
  logic       rst;
  logic       ENABLE;
  logic [7:0] Din;
  logic       ready;
  logic [2:0] Aout;
  logic       valid;
  logic [7:0] pending;
  logic [3:0] pend_cnt;
  logic       dup;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] din;
    logic       rdy;
    logic       v;
    logic [2:0] a;
    logic [7:0] p;
    logic [3:0] c;
    logic       d;
  } vec_t;

  vec_t vecs[$];

  req_encoder8 dut (
    .clk     (clk),
    .rst     (rst),
    .ENABLE  (ENABLE),
    .Din     (Din),
    .ready   (ready),
    .Aout    (Aout),
    .valid   (valid),
    .pending (pending),
    .pend_cnt(pend_cnt),
    .dup     (dup)
  );

  always #5 clk = ~clk;

  function automatic void add(logic r, logic en, logic [7:0] din, logic rdy,
                              logic v, logic [2:0] a, logic [7:0] p, logic [3:0] c, logic d);
    vec_t t;
    t.rst = r; t.en = en; t.din = din; t.rdy = rdy;
    t.v = v; t.a = a; t.p = p; t.c = c; t.d = d;
    vecs.push_back(t);
  endfunction

  task automatic chk(string name, int idx, logic [7:0] act, logic [7:0] exp);
    if (act !== exp) begin
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
      n_err++;
    end
  endtask

  task automatic apply(vec_t t, int idx);
    @(negedge clk);
    rst = t.rst; ENABLE = t.en; Din = t.din; ready = t.rdy;
    @(posedge clk);
    #1;
    n_vec++;
    chk("valid", idx, {7'd0, valid}, {7'd0, t.v});
    if (t.v) chk("Aout", idx, {5'd0, Aout}, {5'd0, t.a});
    chk("pending", idx, pending, t.p);
    chk("pend_cnt", idx, {4'd0, pend_cnt}, {4'd0, t.c});
    chk("dup", idx, {7'd0, dup}, {7'd0, t.d});
  endtask

  initial begin
    rst = 1'b1; ENABLE = 1'b0; Din = 8'd0; ready = 1'b0;

    //   rst en  din    rdy | v  a  pend   cnt dup
    // reset then single request: grant appears two edges after Din, for one cycle
    add(1, 0, 8'h00, 1,   0, 0, 8'h00, 0, 0);
    add(1, 0, 8'h00, 1,   0, 0, 8'h00, 0, 0);
    add(0, 1, 8'h20, 1,   0, 0, 8'h20, 1, 0);
    add(0, 1, 8'h00, 1,   1, 5, 8'h00, 0, 0);
    add(0, 1, 8'h00, 1,   0, 0, 8'h00, 0, 0);
    // multi-hot burst, back-to-back grants
    add(1, 0, 8'h00, 1,   0, 0, 8'h00, 0, 0);
    add(0, 1, 8'h96, 1,   0, 0, 8'h96, 4, 0);
    add(0, 1, 8'h00, 1,   1, 1, 8'h94, 3, 0);
    add(0, 1, 8'h00, 1,   1, 2, 8'h90, 2, 0);
    add(0, 1, 8'h00, 1,   1, 4, 8'h80, 1, 0);
    add(0, 1, 8'h00, 1,   1, 7, 8'h00, 0, 0);
    add(0, 1, 8'h00, 1,   0, 0, 8'h00, 0, 0);
    // backpressure: five cycles of ready=0
    add(1, 0, 8'h00, 1,   0, 0, 8'h00, 0, 0);
    add(0, 1, 8'h03, 0,   0, 0, 8'h03, 2, 0);
    add(0, 1, 8'h00, 0,   1, 0, 8'h02, 1, 0);
    add(0, 1, 8'h00, 0,   1, 0, 8'h02, 1, 0);
    add(0, 1, 8'h00, 0,   1, 0, 8'h02, 1, 0);
    add(0, 1, 8'h00, 0,   1, 0, 8'h02, 1, 0);
    add(0, 1, 8'h00, 1,   1, 1, 8'h00, 0, 0);
    add(0, 1, 8'h00, 1,   0, 0, 8'h00, 0, 0);
    // duplicate while pending (index 0 held so index 3 waits)
    add(1, 0, 8'h00, 1,   0, 0, 8'h00, 0, 0);
    add(0, 1, 8'h01, 0,   0, 0, 8'h01, 1, 0);
    add(0, 1, 8'h08, 0,   1, 0, 8'h08, 1, 0);
    add(0, 1, 8'h08, 0,   1, 0, 8'h08, 1, 1);
    add(0, 1, 8'h00, 0,   1, 0, 8'h08, 1, 0);
    add(0, 1, 8'h00, 1,   1, 3, 8'h00, 0, 0);
    add(0, 1, 8'h00, 1,   0, 0, 8'h00, 0, 0);
    // clear race: bit 3 re-asserted in the cycle it is loaded
    add(1, 0, 8'h00, 1,   0, 0, 8'h00, 0, 0);
    add(0, 1, 8'h08, 1,   0, 0, 8'h08, 1, 0);
    add(0, 1, 8'h08, 1,   1, 3, 8'h08, 1, 0);
    add(0, 1, 8'h00, 1,   1, 3, 8'h00, 0, 0);
    add(0, 1, 8'h00, 1,   0, 0, 8'h00, 0, 0);
    // ENABLE low blocks capture; reset mid-drain discards everything
    add(1, 0, 8'h00, 1,   0, 0, 8'h00, 0, 0);
    add(0, 0, 8'hFF, 1,   0, 0, 8'h00, 0, 0);
    add(0, 0, 8'hFF, 1,   0, 0, 8'h00, 0, 0);
    add(0, 1, 8'hF0, 1,   0, 0, 8'hF0, 4, 0);
    add(0, 1, 8'h00, 1,   1, 4, 8'hE0, 3, 0);
    add(0, 1, 8'h00, 1,   1, 5, 8'hC0, 2, 0);
    add(0, 1, 8'h00, 1,   0, 0, 8'h00, 0, 0);
    vecs[$].rst = 1'b1;
    add(0, 1, 8'h00, 1,   0, 0, 8'h00, 0, 0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Fairness sequence: bit 0 re-requested in the same cycle it is loaded.
    apply('{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0}, 100);
    apply('{1'b0, 1'b1, 8'h81, 1'b1, 1'b0, 3'd0, 8'h81, 4'd2, 1'b0}, 101);
    apply('{1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 3'd0, 8'h81, 4'd2, 1'b0}, 102);
`ifdef REQ_ENC_RR_EN
    apply('{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 3'd7, 8'h01, 4'd1, 1'b0}, 103);
    apply('{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 3'd0, 8'h00, 4'd0, 1'b0}, 104);
`else
    apply('{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 3'd0, 8'h80, 4'd1, 1'b0}, 103);
    apply('{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 3'd7, 8'h00, 4'd0, 1'b0}, 104);
`endif
    apply('{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0}, 105);

    // ready while idle must be ignored, and ENABLE low must also suppress dup
    apply('{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0}, 106);
    apply('{1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 3'd0, 8'h44, 4'd2, 1'b0}, 107);
    apply('{1'b0, 1'b0, 8'h44, 1'b0, 1'b1, 3'd2, 8'h40, 4'd1, 1'b0}, 108);
    apply('{1'b0, 1'b0, 8'h40, 1'b0, 1'b1, 3'd2, 8'h40, 4'd1, 1'b0}, 109);
    apply('{1'b0, 1'b1, 8'h40, 1'b0, 1'b1, 3'd2, 8'h40, 4'd1, 1'b1}, 110);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/req_encoder8.md
# req_encoder8

Sequential 8-to-3 request encoder: the inverse of the register file's 3-to-8 write-select decoder. It collects one-hot or multi-hot request lines from up to eight sources, holds them as pending, and emits one 3-bit index at a time over a valid/ready handshake. It sits in front of the register file address port, so independent requesters can each be serialised into a single address stream.

## Interface

Parameters:
- none; width is fixed at 8 requests / 3-bit index.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `ENABLE`  in  1  when 0, `Din` is ignored and nothing new is captured; pending requests still drain.
- `Din`  in  8  request lines; bit i high in a cycle = one request for index i.
- `ready`  in  1  consumer accepts `Aout` this cycle when `valid` is also high.
- `Aout`  out  3  granted index.
- `valid`  out  1  `Aout` holds a granted index.
- `pending`  out  8  registered pending-request vector.
- `pend_cnt`  out  4  population count of `pending`, 0..8; combinational from the `pending` register.
- `dup`  out  1  one-cycle pulse: a request arrived for an index that is already pending and not being cleared.

## Operation

- Reset values: `pending`=0, `valid`=0, `Aout`=0, `dup`=0, `pend_cnt`=0, round-robin pointer `last`=7.
- Capture. Each cycle: `pending` <= (`pending` & ~`clr`) | (`ENABLE` ? `Din` : 0).
  - `clr` is the one-hot of the index being loaded into the output register this cycle, else 0.
  - A request arriving on the same index being cleared stays pending, so it is never lost.
- Output stage, two states:
  - IDLE (`valid`=0): if `pending`≠0, select index s, load `Aout`<=s, `valid`<=1, `clr`=1<<s, and go to HOLD.
  - HOLD (`valid`=1): `Aout` and `valid` are held until `ready`=1.
    - On `ready`, if `pending`≠0: load the next s with no bubble and stay in HOLD.
    - On `ready`, if `pending`=0: `valid`<=0 and go to IDLE.
- Selection uses only the registered `pending`; same-cycle `Din` is never granted.
- Default selection is fixed priority: the lowest set index wins.
- `dup` <= `ENABLE` & |(`Din` & `pending` & ~`clr`).
- `ready` while `valid`=0 is ignored.

## Timing

- Latency: `Din` bit asserted at edge N → `pending` set after edge N → `valid`/`Aout` after edge N+1.
  - That is 2 cycles in IDLE when nothing is pending ahead of the new request.
- Throughput: one grant per cycle while `ready` is held high and `pending`≠0.
- Simultaneous events:
  - Multiple `Din` bits in one cycle are all captured.
  - A grant and a new capture in the same cycle both take effect.
- Reset mid-operation: on the next edge all state returns to reset values and any pending or held grants are discarded.
- `pend_cnt` tracks `pending` in the same cycle. It excludes the index held in `Aout`.

## Configuration

- `REQ_ENC_RR_EN` defined: round-robin selection.
  - The search starts at (`last`+1) mod 8, wraps through 7→0, and picks the first set bit.
  - `last` <= s on every load.
  - Because `last` resets to 7, the first grant after reset matches fixed priority.
- `REQ_ENC_RR_EN` undefined: fixed lowest-index priority. `last` does not exist.

## Test plan

- Reset then single request:
  - Stimulus: assert `rst` 2 cycles; `ENABLE`=1, `Din`=8'h20 for 1 cycle; `ready`=1.
  - Required: `valid`=1 with `Aout`=5 exactly 2 cycles after `Din`, for 1 cycle.
  - Required: `pending` and `pend_cnt` return to 0.
- Multi-hot burst, fixed priority:
  - Stimulus: `Din`=8'b1001_0110 once; `ready`=1.
  - Required: `Aout` sequence 1,2,4,7 on consecutive cycles with no bubble.
  - Required: `pend_cnt` steps 4→3→2→1→0.
- Backpressure:
  - Stimulus: `Din`=8'h03; `ready`=0 for 5 cycles, then 1.
  - Required: `Aout`=0 and `valid`=1 stable throughout the stall, then `Aout`=1, then `valid`=0.
- Duplicate and clear race:
  - Stimulus: `Din`=8'h08 held 1 cycle, repeated while pending.
  - Required: `dup` pulses once, and index 3 is granted once.
  - Stimulus: re-assert bit 3 in the same cycle it is loaded.
  - Required: index 3 is granted twice.
- `ENABLE` and reset mid-drain:
  - Stimulus: `ENABLE`=0 with `Din`=8'hFF.
  - Required: nothing is captured.
  - Stimulus: `Din`=8'hF0, 2 grants, then `rst`.
  - Required: `valid`=0 and `pending`=0 on the next edge.
- Round-robin (`REQ_ENC_RR_EN`):
  - Stimulus: `Din`=8'h81; grant 0; re-request bit 0 before the next load.
  - Required: next `Aout`=7, then 0 (wrap-around fairness).
